square_puls_analyzer: RTL

Sink-side counterpart of the square-pulse generator chain. It paces a sample source by issuing next-data request strobes at a fixed divided rate and consumes the returned signed samples with their valid strobes. It slices each sample against a threshold and measures the pulse period and high time in samples. On every rising edge it publishes the measurements with a one-cycle valid strobe. It sits downstream of any signed N_FRAC+1-bit strobe-handshake source, for example the square-pulse generator or the CORDIC outputs.

---
 rtl/square_puls_analyzer_pkg.sv | 24 ++
 rtl/square_puls_analyzer_divider.sv | 38 +++
 rtl/square_puls_analyzer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/square_puls_analyzer_pkg.sv
// Shared definitions for the square-pulse analyzer: FSM encoding and the
// full-scale sample constants used by the matching generator.
`ifndef SQUARE_PULS_ANALYZER_PKG_SV
`define SQUARE_PULS_ANALYZER_PKG_SV

package square_puls_analyzer_pkg;

  // Analyzer FSM: SYNC waits for the first genuine rising edge,
  // MEASURE accumulates period/high counts between rising edges.
  typedef enum logic {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Default fractional width of the sample stream (Q0.7).
  localparam int DEF_N_FRAC = 7;

  // Full-scale positive and negative sample values of the generator.
  localparam logic signed [DEF_N_FRAC:0] ONE       = {1'b0, {DEF_N_FRAC{1'b1}}};
  localparam logic signed [DEF_N_FRAC:0] MINUS_ONE = {1'b1, {DEF_N_FRAC{1'b0}}};

endpackage

`endif

// File: rtl/square_puls_analyzer_divider.sv
// Request pacer: emits a one-cycle sample request every SAMPLE_DIV clocks
// while enabled. The counter is held at zero while disabled so the first
// request after enabling always arrives SAMPLE_DIV cycles later.
module sample_request_divider #(
  parameter int SAMPLE_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic next_data_strobe_o
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             strobe_reg;

  // Free-running modulo-SAMPLE_DIV counter; strobe registered on wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_reg <= '0;
      strobe_reg  <= 1'b0;
    end else if (!enable_i) begin
      div_cnt_reg <= '0;
      strobe_reg  <= 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
      strobe_reg  <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
      strobe_reg  <= 1'b0;
    end
  end

  assign next_data_strobe_o = strobe_reg;

endmodule

// File: rtl/square_puls_analyzer.sv
// Square-pulse analyzer: paces a sample source, slices each accepted sample
// against a threshold and measures period and high time (in samples)
// between consecutive rising edges, publishing one strobe per rising edge.
module square_puls_analyzer
  import square_puls_analyzer_pkg::*;
#(
  parameter int N_FRAC     = 7,
  parameter int SAMPLE_DIV = 4,
  parameter int CNT_W      = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic signed [N_FRAC:0]  data_i,
  input  logic                    data_in_valid_strobe_i,
  input  logic signed [N_FRAC:0]  threshold_i,
  output logic                    next_data_strobe_o,
  output logic [CNT_W-1:0]        period_o,
  output logic [CNT_W-1:0]        high_count_o,
  output logic                    meas_valid_strobe_o,
  output logic                    locked_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] period_cnt_reg, period_cnt_next;
  logic [CNT_W-1:0] high_cnt_reg, high_cnt_next;
  logic [CNT_W-1:0] period_out_reg, period_out_next;
  logic [CNT_W-1:0] high_out_reg, high_out_next;
  logic             meas_valid_reg, meas_valid_next;
  logic             locked_reg, locked_next;
  logic             prev_level_reg, prev_level_next;

  logic accept;
  logic level;
  logic rise;
  logic overflow;

  sample_request_divider #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_divider (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .next_data_strobe_o (next_data_strobe_o)
  );

  // Slicer: a sample equal to the threshold counts as high. prev_level
  // starts at 1 so a stream that begins high is not mistaken for an edge.
  assign accept   = enable_i & data_in_valid_strobe_i;
  assign level    = (data_i >= threshold_i);
  assign rise     = level & ~prev_level_reg;
  assign overflow = (period_cnt_reg == CNT_MAX);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= SYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: disabling or counter overflow forces a resync.
  always_comb begin
    state_next = state_reg;
    if (!enable_i) begin
      state_next = SYNC;
    end else if (accept) begin
      case (state_reg)
        SYNC:    if (rise) state_next = MEASURE;
        MEASURE: if (!rise && overflow) state_next = SYNC;
        default: state_next = SYNC;
      endcase
    end
  end

  // Datapath/output next values: counters, published measurements, lock.
  always_comb begin
    period_cnt_next = period_cnt_reg;
    high_cnt_next   = high_cnt_reg;
    period_out_next = period_out_reg;
    high_out_next   = high_out_reg;
    meas_valid_next = 1'b0;
    locked_next     = locked_reg;
    prev_level_next = prev_level_reg;
    if (!enable_i) begin
      period_cnt_next = '0;
      high_cnt_next   = '0;
      locked_next     = 1'b0;
      prev_level_next = 1'b1;
    end else if (accept) begin
      prev_level_next = level;
      case (state_reg)
        SYNC: begin
          if (rise) begin
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out_next = period_cnt_reg;
            high_out_next   = high_cnt_reg;
            meas_valid_next = 1'b1;
            locked_next     = 1'b1;
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
          end else if (overflow) begin
            period_cnt_next = '0;
            high_cnt_next   = '0;
            locked_next     = 1'b0;
          end else begin
            period_cnt_next = period_cnt_reg + 1'b1;
            high_cnt_next   = high_cnt_reg + {{(CNT_W-1){1'b0}}, level};
          end
        end
        default: begin
          period_cnt_next = '0;
          high_cnt_next   = '0;
        end
      endcase
    end
  end

  // Datapath registers; reset clears everything and overrides any sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
      period_out_reg <= '0;
      high_out_reg   <= '0;
      meas_valid_reg <= 1'b0;
      locked_reg     <= 1'b0;
      prev_level_reg <= 1'b1;
    end else begin
      period_cnt_reg <= period_cnt_next;
      high_cnt_reg   <= high_cnt_next;
      period_out_reg <= period_out_next;
      high_out_reg   <= high_out_next;
      meas_valid_reg <= meas_valid_next;
      locked_reg     <= locked_next;
      prev_level_reg <= prev_level_next;
    end
  end

  assign period_o            = period_out_reg;
  assign high_count_o        = high_out_reg;
  assign meas_valid_strobe_o = meas_valid_reg;
  assign locked_o            = locked_reg;

endmodule
